// File: rtl/pipelined_shifter.sv
// pipelined_shifter: barrel shifter with one registered stage per shift-amount bit and valid/ready on both sides.
// Optional Out_Zero/Out_Neg result flags are built in when SHIFTER_FLAGS_EN is defined.
module pipelined_shifter #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned TAG_W = 4,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Shift_In,
    input  logic [SHW-1:0]   Shift_Val,
    input  logic [2:0]       Mode,
    input  logic [TAG_W-1:0] In_Tag,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Shift_Out,
`ifdef SHIFTER_FLAGS_EN
    output logic             Out_Zero,
    output logic             Out_Neg,
`endif
    output logic [TAG_W-1:0] Out_Tag
);

    // One partial shift of a fixed amount. SRA stays correct across stages because
    // every arithmetic step preserves the operand MSB.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input int unsigned      amt
    );
        logic [WIDTH-1:0] res;
        casez (mode)
            3'b000:  res = d << amt;
            3'b001:  res = WIDTH'($signed(d) >>> amt);
            3'b01?:  res = (d >> amt) | (d << (WIDTH - amt));
            3'b100:  res = d >> amt;
            3'b101:  res = (d << amt) | (d >> (WIDTH - amt));
            default: res = d;
        endcase
        return res;
    endfunction

    // Index k is the input side of stage k; index SHW is the output side of the last stage.
    logic             w_v    [SHW+1];
    logic [WIDTH-1:0] w_d    [SHW+1];
    logic [TAG_W-1:0] w_t    [SHW+1];
    logic             w_adv  [SHW+1];
    logic [SHW-1:0]   w_sh   [SHW];
    logic [2:0]       w_mode [SHW];

    assign w_v[0]     = In_Valid;
    assign w_d[0]     = Shift_In;
    assign w_t[0]     = In_Tag;
    assign w_sh[0]    = Shift_Val;
    assign w_mode[0]  = Mode;
    assign w_adv[SHW] = Out_Ready;

    assign In_Ready  = w_adv[0];
    assign Out_Valid = w_v[SHW];
    assign Shift_Out = w_d[SHW];
    assign Out_Tag   = w_t[SHW];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned AMT = 1 << k;

        logic             w_step;
        logic [WIDTH-1:0] w_res;
        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic [TAG_W-1:0] r_tag;

        assign w_step   = w_sh[k][k];
        assign w_res    = w_step ? f_step(w_d[k], w_mode[k], AMT) : w_d[k];
        // A stage loads when it is empty or its successor is taking its content.
        assign w_adv[k] = !r_valid || w_adv[k+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_tag   <= '0;
            end else if (w_adv[k]) begin
                r_valid <= w_v[k];
                if (w_v[k]) begin
                    r_data <= w_res;
                    r_tag  <= w_t[k];
                end
            end
        end

        assign w_v[k+1] = r_valid;
        assign w_d[k+1] = r_data;
        assign w_t[k+1] = r_tag;

        // Shift amount and mode are only needed by later stages.
        if (k < SHW - 1) begin : g_ctl
            logic [SHW-1:0] r_sh;
            logic [2:0]     r_mode;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sh   <= '0;
                    r_mode <= '0;
                end else if (w_adv[k] && w_v[k]) begin
                    r_sh   <= w_sh[k];
                    r_mode <= w_mode[k];
                end
            end

            assign w_sh[k+1]   = r_sh;
            assign w_mode[k+1] = r_mode;
        end
    end

`ifdef SHIFTER_FLAGS_EN
    // Flags are captured together with the last-stage data so they share its validity.
    logic r_zero;
    logic r_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_adv[SHW-1] && w_v[SHW-1]) begin
            r_zero <= (g_stage[SHW-1].w_res == '0);
            r_neg  <= g_stage[SHW-1].w_res[WIDTH-1];
        end
    end

    assign Out_Zero = r_zero;
    assign Out_Neg  = r_neg;
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed self-checking bench for pipelined_shifter: a WIDTH=16 instance for modes, streaming,
// backpressure and reset, plus a WIDTH=32 instance for latency and the optional flags.
module tb_pipelined_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] shift_in, shift_out;
    logic [3:0]  shift_val, in_tag, out_tag;
    logic [2:0]  mode;

    logic        v32, rdy32, ov32, ordy32;
    logic [31:0] din32, dout32;
    logic [4:0]  sh32;
    logic [2:0]  m32;
    logic [3:0]  t32, ot32;
`ifdef SHIFTER_FLAGS_EN
    logic        zero32, neg32, zero16, neg16;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_shifter #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .In_Valid(in_valid), .In_Ready(in_ready),
        .Shift_In(shift_in), .Shift_Val(shift_val), .Mode(mode), .In_Tag(in_tag),
        .Out_Valid(out_valid), .Out_Ready(out_ready),
        .Shift_Out(shift_out),
`ifdef SHIFTER_FLAGS_EN
        .Out_Zero(zero16), .Out_Neg(neg16),
`endif
        .Out_Tag(out_tag)
    );

    pipelined_shifter #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .In_Valid(v32), .In_Ready(rdy32),
        .Shift_In(din32), .Shift_Val(sh32), .Mode(m32), .In_Tag(t32),
        .Out_Valid(ov32), .Out_Ready(ordy32),
        .Shift_Out(dout32),
`ifdef SHIFTER_FLAGS_EN
        .Out_Zero(zero32), .Out_Neg(neg32),
`endif
        .Out_Tag(ot32)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    // Single operation on the 16-bit instance; checks acceptance, latency, result and tag.
    task automatic do_op(input string name, input logic [2:0] m, input logic [15:0] d,
                         input logic [3:0] s, input logic [3:0] t, input logic [15:0] exp);
        int n = 0;
        mode = m; shift_in = d; shift_val = s; in_tag = t; in_valid = 1'b1;
        #1;
        chk({name, " ready"}, 32'(in_ready), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = i;
            if (out_valid) break;
        end
        chk({name, " latency"}, 32'(n), 32'd4);
        chk({name, " data"}, 32'(shift_out), 32'(exp));
        chk({name, " tag"}, 32'(out_tag), 32'(t));
        @(posedge clk); #1;
    endtask

    task automatic do_op32(input string name, input logic [2:0] m, input logic [31:0] d,
                           input logic [4:0] s, input logic [31:0] exp);
        int n = 0;
        m32 = m; din32 = d; sh32 = s; t32 = 4'hA; v32 = 1'b1;
        #1;
        chk({name, " ready"}, 32'(rdy32), 32'd1);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            v32 = 1'b0;
            n = i;
            if (ov32) break;
        end
        chk({name, " latency"}, 32'(n), 32'd5);
        chk({name, " data"}, dout32, exp);
        chk({name, " tag"}, 32'(ot32), 32'hA);
`ifdef SHIFTER_FLAGS_EN
        chk({name, " zero"}, 32'(zero32), 32'(exp == 32'd0));
        chk({name, " neg"}, 32'(neg32), 32'(exp[31]));
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int idx;
        int rcv;
        logic acc;

        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        shift_in = '0; shift_val = '0; mode = '0; in_tag = '0;
        v32 = 1'b0; ordy32 = 1'b1; din32 = '0; sh32 = '0; m32 = '0; t32 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset shift_out", 32'(shift_out), 32'd0);
        chk("reset out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        do_op("sll", 3'b000, 16'h1234, 4'd4,  4'd1, 16'h2340);
        do_op("sra", 3'b001, 16'h8000, 4'd15, 4'd2, 16'hFFFF);
        do_op("srl", 3'b100, 16'h8000, 4'd15, 4'd3, 16'h0001);
        do_op("ror", 3'b010, 16'h00F1, 4'd4,  4'd4, 16'h100F);
        do_op("ror011", 3'b011, 16'h0001, 4'd1, 4'd5, 16'h8000);
        do_op("rol", 3'b101, 16'h8001, 4'd1,  4'd6, 16'h0003);
        do_op("pass", 3'b110, 16'hABCD, 4'd7, 4'd7, 16'hABCD);
        do_op("sra by 0", 3'b001, 16'h8000, 4'd0, 4'd8, 16'h8000);
        do_op("rol by 0", 3'b101, 16'h8421, 4'd0, 4'd9, 16'h8421);

        // Back-to-back: op c is SLL 1 by c, tag c; result c emerges after edge c+3.
        for (int c = 0; c < 13; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; mode = 3'b000; shift_in = 16'h0001;
                shift_val = 4'(c); in_tag = 4'(c);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 8) chk("b2b in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            if (c >= 3 && c < 11) begin
                chk("b2b out_valid", 32'(out_valid), 32'd1);
                chk("b2b data", 32'(shift_out), 32'(16'h0001 << (c - 3)));
                chk("b2b tag", 32'(out_tag), 32'(c - 3));
            end else begin
                chk("b2b bubble", 32'(out_valid), 32'd0);
            end
        end

        // Backpressure: op i is SRL 0x8000 by i, tag i.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; mode = 3'b100; shift_in = 16'h8000;
            shift_val = 4'(idx); in_tag = 4'(idx);
            #1;
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (c >= 4) begin
                chk("bp hold valid", 32'(out_valid), 32'd1);
                chk("bp hold data", 32'(shift_out), 32'h8000);
                chk("bp hold tag", 32'(out_tag), 32'd0);
            end
        end
        chk("bp accepted", 32'(idx), 32'd4);
        shift_val = 4'(idx); in_tag = 4'(idx);
        #1;
        chk("bp full in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp push+pop in_ready", 32'(in_ready), 32'd1);
        rcv = 0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            if (idx < 8) begin
                in_valid = 1'b1; shift_val = 4'(idx); in_tag = 4'(idx);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("bp drain data", 32'(shift_out), 32'(16'h8000 >> rcv));
                chk("bp drain tag", 32'(out_tag), 32'(rcv));
                rcv++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp received", 32'(rcv), 32'd8);
        chk("bp all accepted", 32'(idx), 32'd8);
        #1;
        chk("bp no duplicate", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Reset with three ops in flight; last stage still holds the old 0x0100/tag 7.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; mode = 3'b000; shift_in = 16'hFFFF; shift_val = 4'd0; in_tag = 4'd9;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre-reset stale data", 32'(shift_out), 32'h0100);
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", 32'(out_valid), 32'd0);
        chk("mid reset shift_out", 32'(shift_out), 32'd0);
        chk("mid reset out_tag", 32'(out_tag), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post reset in_ready", 32'(in_ready), 32'd1);
        do_op("post reset sll", 3'b000, 16'h0001, 4'd15, 4'd3, 16'h8000);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("no stale result", 32'(out_valid), 32'd0);
        end

        do_op32("w32 ror", 3'b010, 32'h0000_0001, 5'd31, 32'h0000_0002);
        do_op32("w32 sll", 3'b000, 32'h8000_0000, 5'd1,  32'h0000_0000);
        do_op32("w32 sra", 3'b001, 32'h8000_0000, 5'd4,  32'hF800_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, fully pipelined barrel shifter. Successor to the fixed 16-bit combinational shifter.
- Adds a generic data width, two more modes (SRL, ROL), one register stage per shift bit, and valid/ready handshakes on both sides.
- Sits between the ALU operand mux and the writeback path. Sustains one operation per cycle with full backpressure.

Parameters:
- WIDTH, 16, data width in bits; must be a power of two, >= 4.
- TAG_W, 4, width of the opaque sideband tag carried alongside each operation.
- SHW (localparam), log2(WIDTH), shift-amount width; also the number of pipeline stages.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- In_Valid  input  1  input operation present
- In_Ready  output  1  pipeline can accept the input this cycle
- Shift_In  input  WIDTH  operand
- Shift_Val  input  SHW  shift amount, 0..WIDTH-1
- Mode  input  3  000 SLL, 001 SRA, 01x ROR, 100 SRL, 101 ROL, 11x pass-through
- In_Tag  input  TAG_W  sideband; returned unchanged with the result
- Out_Valid  output  1  result present
- Out_Ready  input  1  consumer accepts the result
- Shift_Out  output  WIDTH  result
- Out_Tag  output  TAG_W  tag of the operation at the output

Behaviour:
- Mode encoding when Mode[2]=0 is identical to the legacy 2-bit encoding.
- SRL fills with 0. SRA fills with operand MSB. ROR/ROL rotate right/left. Pass-through outputs Shift_In unchanged.
- Stage k (k = 0..SHW-1):
  - applies a shift of 2^k when Shift_Val[k]=1, otherwise passes data through;
  - registers data, remaining shift bits, Mode, tag and a valid bit.
- Shift amount 0 → Shift_Out equals Shift_In in every mode.
- Latency is exactly SHW cycles from an accepted input (In_Valid & In_Ready) to Out_Valid, given no stall. WIDTH=16 → 4 cycles.
- Throughput: one operation per cycle while Out_Ready=1.
- Stage advance rule: stage k loads when (stage k empty) or (stage k+1 accepts). The last stage frees when Out_Ready=1.
- In_Ready = !valid0 | stage0_advances. This is combinational from Out_Ready through the stall chain. No skid buffer.
- Out_Valid is the last-stage valid bit. Shift_Out and Out_Tag come directly from last-stage registers.
- Out_Valid, once asserted, stays high and data stays stable until Out_Ready=1.
- Pipeline full with Out_Ready=0 → In_Ready=0. No operation is dropped or duplicated.
- Simultaneous pop and push on a full pipeline → both occur in the same cycle; occupancy is unchanged.
- In_Valid=0 → bubbles propagate. Bubbles never assert Out_Valid.
- Reset (async assert, sync-style deassert expected from the top level):
  - all valid bits 0, all data/tag registers 0;
  - Out_Valid=0, Shift_Out=0, Out_Tag=0;
  - In_Ready=1 on the first cycle after release;
  - operations in flight when reset asserts are discarded.
- Out-of-range Shift_Val cannot occur because the width is exactly SHW.

Optional Feature:
- Macro: SHIFTER_FLAGS_EN.
- Defined:
  - adds outputs Out_Zero (1 bit) and Out_Neg (1 bit), registered in the last stage alongside Shift_Out;
  - Out_Zero = (Shift_Out == 0); Out_Neg = Shift_Out[WIDTH-1];
  - same validity and stability rules as Shift_Out; both reset to 0.
- Not defined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- WIDTH=16, single ops with Out_Ready=1 and checks on each result:
  - SLL 0x1234 by 4 → 0x2340;
  - SRA 0x8000 by 15 → 0xFFFF;
  - SRL 0x8000 by 15 → 0x0001;
  - ROR 0x00F1 by 4 → 0x100F;
  - ROL 0x8001 by 1 → 0x0003;
  - Mode 110, 0xABCD by 7 → 0xABCD;
  - every result appears exactly 4 cycles after acceptance.
- Back-to-back: 8 ops, tags 0..7, on consecutive cycles → 8 results on 8 consecutive cycles, in order, with matching tags.
- Backpressure: Out_Ready=0 while streaming 8 ops → In_Ready drops after 4 acceptances and Out_Valid holds op 0 stable. Releasing Out_Ready → remaining ops complete in order with no loss.
- Reset mid-stream: rst_n low with 3 ops in flight → Out_Valid=0 and Shift_Out=0 immediately. After release, the first new op (SLL 0x0001 by 15) → 0x8000 after 4 cycles; no stale results appear.
- WIDTH=32 build: ROR 0x00000001 by 31 → 0x00000002, latency 5. With SHIFTER_FLAGS_EN: SLL 0x80000000 by 1 → Out_Zero=1, Out_Neg=0.
